lfsr_axil_slave: RTL and testbench
==================================

# lfsr_axil_slave

AXI4-Lite responder exposing a 32-bit Galois LFSR to a bus master through a register file. It is the slave end of the S00_AXI interface in the LFSR_beta peripheral, and is driven by the Master VIP in the block-design bench. It owns the AXI4-Lite handshakes, the control, seed, taps and limit registers, and a free-running or step-limited LFSR whose state is also exported on a side port.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decode uses addr[4:2].
- s00_axi_aclk  in  1  single clock, rising edge.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  5/3/1/1  write address channel; prot is ignored.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  5/3/1/1  read address channel; prot is ignored.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- lfsr_out  out  32  current LFSR state.
- lfsr_valid  out  1  one-cycle pulse in the cycle after each LFSR advance.

## Operation
Register map, byte offsets:
- 0x00 CTRL, RW. Bit0 is RUN. Bits 31:1 are stored and read back, with no other function.
- 0x04 SEED, RW. A write commit loads STATE with the merged SEED value and clears COUNT. A merged value of 0 loads STATE with 0x00000001 instead; SEED itself still reads back 0.
- 0x08 TAPS, RW. Galois feedback mask.
- 0x0C LIMIT, RW. 0 means unlimited.
- 0x10 STATE, RO.
- 0x14 COUNT, RO. Counts steps since the last seed load. Saturates at 0xFFFFFFFF.
- 0x18 and 0x1C: reads return 0; writes are ignored.
- All responses are OKAY (2'b00). Writes to RO or unmapped offsets still complete normally.
- wstrb[n] enables byte n on RW registers; disabled bytes keep their old value.

LFSR step:
- Enable condition: RUN=1 and (LIMIT==0 or COUNT<LIMIT).
- Next state: (STATE>>1) ^ (STATE[0] ? TAPS : 0).
- Each step increments COUNT.
- A SEED commit in the same cycle takes precedence: no step occurs and COUNT becomes 0.

Reset values:
- CTRL, SEED, LIMIT, COUNT = 0. TAPS = 0x80200003. STATE = 0x00000001.
- All ready/valid outputs = 0. bresp, rresp, rdata = 0. lfsr_valid = 0.

## Timing
Write channel:
- When awvalid & wvalid & !awready & !bvalid are all true at a clock edge, awready and wready are 1 for exactly the following cycle. Both are registered.
- The register commit happens on the edge that ends that cycle.
- bvalid rises on the cycle after the commit and holds until bready is sampled high.
- No new address/data is accepted while bvalid=1.
- An AW without W, or W without AW, waits indefinitely; it is never accepted alone.
- Minimum latency: valids at cycle 0, readies at cycle 1, bvalid at cycle 2.

Read channel:
- When arvalid & !arready & !rvalid, arready is 1 for one cycle and the address is latched.
- rdata is registered from the register value at that handshake edge. rvalid rises the next cycle.
- rdata/rresp are held stable while rvalid=1 and rready=0.
- No new AR is accepted while rvalid=1.

Concurrency:
- The read and write channels are independent.
- A read racing a write to the same register returns the pre-commit value if both handshakes land on the same edge.
- STATE/COUNT reads return the value as of the AR handshake edge.

Reset:
- Asserting s00_axi_aresetn low clears all outputs and registers immediately, including mid-transaction.
- In-flight transactions are dropped; the master reissues them.
- Outputs stay at reset values until the first clock edge after release.

## Test plan
- Readback: write 0x1, 0x2, 0x3, 0x4 to 0x00–0x0C, then read 0x00–0x0C -> 0x1, 0x2, 0x3, 0x4, all with OKAY. Read 0x18 -> 0x0, OKAY.
- Stepping: with CTRL=0, write TAPS=0x80200003, SEED=0x1, LIMIT=3, then CTRL=1 -> exactly 3 lfsr_valid pulses. STATE reads 0x60180001 (sequence 0x80200003, 0xC0300002, 0x60180001) and COUNT reads 3. STATE is unchanged 20 cycles later.
- Zero seed: write SEED=0 -> STATE=0x00000001, SEED reads 0, COUNT=0.
- Strobes: with RUN=0 and SEED=0, write 0xAABBCCDD with wstrb=4'b0101 -> SEED=0x00BB00DD and STATE=0x00BB00DD.
- Backpressure: hold bready low 5 cycles -> bvalid stays 1 and a queued AW/W is not accepted until 1 cycle after B completes. Hold rready low 5 cycles during a STATE read with RUN=1 -> rdata stays constant.
- Reset mid-read: drop aresetn while rvalid=1 -> rvalid=0 asynchronously. After release, TAPS reads 0x80200003 and STATE reads 0x1.

Source files
------------

// File: rtl/lfsr_axil_slave_if.sv
// AXI4-Lite bus bundle between the LFSR peripheral and its master.
// Widths follow the slave's data/address parameters.
interface lfsr_axil_slave_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/lfsr_axil_slave.sv
// AXI4-Lite register file around a 32-bit Galois LFSR.
// Free-running or step-limited; state exported on lfsr_out.
module lfsr_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  lfsr_axil_slave_if.slave       s00_axi,
  output logic [31:0]            lfsr_out,
  output logic                   lfsr_valid
);
  localparam int NB   = C_S_AXI_DATA_WIDTH / 8;
  localparam int AMSB = C_S_AXI_ADDR_WIDTH - 1;
  localparam logic [31:0] TAPS_RST = 32'h8020_0003;

  logic [31:0] ctrl_q, ctrl_d, seed_q, seed_d;
  logic [31:0] taps_q, taps_d, limit_q, limit_d;
  logic [31:0] state_q, state_d, count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic        lfsr_valid_q, lfsr_valid_d;

  logic [2:0]  waddr, raddr;
  logic [31:0] wr_old, wr_val, rd_val;
  logic        wr_en, ar_hs, seed_wr, step;
  logic        unused;

  assign waddr  = s00_axi.awaddr[AMSB:2];
  assign raddr  = s00_axi.araddr[AMSB:2];
  assign unused = ^{s00_axi.awprot, s00_axi.arprot,
                    s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  function automatic logic [31:0] merge(
    input logic [31:0]   old,
    input logic [31:0]   wd,
    input logic [NB-1:0] s
  );
    logic [31:0] m;
    m = old;
    for (int i = 0; i < NB; i++)
      if (s[i]) m[i*8 +: 8] = wd[i*8 +: 8];
    return m;
  endfunction

  always_comb begin
    ctrl_d  = ctrl_q;
    seed_d  = seed_q;
    taps_d  = taps_q;
    limit_d = limit_q;
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    wr_old  = '0;
    rd_val  = '0;

    awready_d = s00_axi.awvalid & s00_axi.wvalid & ~awready_q & ~bvalid_q;
    wready_d  = awready_d;
    wr_en     = awready_q & wready_q;
    bvalid_d  = (bvalid_q & ~s00_axi.bready) | wr_en;

    case (waddr)
      3'd0:    wr_old = ctrl_q;
      3'd1:    wr_old = seed_q;
      3'd2:    wr_old = taps_q;
      3'd3:    wr_old = limit_q;
      default: wr_old = '0;
    endcase
    wr_val  = merge(wr_old, s00_axi.wdata, s00_axi.wstrb);
    seed_wr = wr_en && (waddr == 3'd1);

    if (wr_en) begin
      case (waddr)
        3'd0:    ctrl_d  = wr_val;
        3'd1:    seed_d  = wr_val;
        3'd2:    taps_d  = wr_val;
        3'd3:    limit_d = wr_val;
        default: ;
      endcase
    end

    // A seed load wins over a step landing on the same edge
    step = ctrl_q[0] && ((limit_q == '0) || (count_q < limit_q)) && !seed_wr;
    lfsr_valid_d = step;
    if (seed_wr) begin
      state_d = (wr_val == '0) ? 32'h1 : wr_val;
      count_d = '0;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? taps_q : '0);
      if (count_q != '1) count_d = count_q + 32'd1;
    end

    case (raddr)
      3'd0:    rd_val = ctrl_q;
      3'd1:    rd_val = seed_q;
      3'd2:    rd_val = taps_q;
      3'd3:    rd_val = limit_q;
      3'd4:    rd_val = state_q;
      3'd5:    rd_val = count_q;
      default: rd_val = '0;
    endcase

    ar_hs     = s00_axi.arvalid & arready_q;
    arready_d = s00_axi.arvalid & ~arready_q & ~rvalid_q;
    rvalid_d  = (rvalid_q & ~s00_axi.rready) | ar_hs;
    if (ar_hs) rdata_d = rd_val;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_q       <= '0;
      seed_q       <= '0;
      taps_q       <= TAPS_RST;
      limit_q      <= '0;
      state_q      <= 32'h1;
      count_q      <= '0;
      rdata_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      lfsr_valid_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      seed_q       <= seed_d;
      taps_q       <= taps_d;
      limit_q      <= limit_d;
      state_q      <= state_d;
      count_q      <= count_d;
      rdata_q      <= rdata_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      lfsr_valid_q <= lfsr_valid_d;
    end
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;
  assign lfsr_out        = state_q;
  assign lfsr_valid      = lfsr_valid_q;
endmodule

// File: tb/tb_lfsr_axil_slave.sv
// Directed bench for lfsr_axil_slave: register map, LFSR stepping,
// strobes, backpressure and asynchronous reset.
module tb_lfsr_axil_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_axil_slave_if #(.AW(5), .DW(32)) bus();
  logic [31:0] lfsr_out;
  logic        lfsr_valid;
  int errors = 0;
  int checks = 0;
  int pulses = 0;

  lfsr_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (bus.slave),
    .lfsr_out        (lfsr_out),
    .lfsr_valid      (lfsr_valid)
  );

  always @(posedge clk) if (lfsr_valid === 1'b1) pulses <= pulses + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r);
    int n;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.awready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL aw_timeout addr=%h awready=%b want 1", a, bus.awready);
    end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.bvalid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL b_timeout addr=%h bvalid=%b want 1", a, bus.bvalid);
    end
    r = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.arready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr=%h arready=%b want 1", a, bus.arready);
    end
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.rvalid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL r_timeout addr=%h rvalid=%b want 1", a, bus.rvalid);
    end
    d = bus.rdata; r = bus.rresp;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] o;
    idle();
    rst_n = 1'b0;
    tick(); tick();
    o = {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
         bus.bresp, bus.rresp, lfsr_valid};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL rst_outs got=%h want=0", o); end
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata got=%h want=0", bus.rdata);
    end
    checks++;
    if (lfsr_out !== 32'h1) begin
      errors++; $display("FAIL rst_state got=%h want=1", lfsr_out);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (lfsr_out !== 32'h1 || lfsr_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got=%h/%b want 1/0", lfsr_out, lfsr_valid);
    end
  endtask

  task automatic test_readback;
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
      checks++;
      if (r !== 2'b00) begin errors++; $display("FAIL bresp got=%b want=00", r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r);
      checks++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        errors++;
        $display("FAIL readback_%0d got=%h/%b want=%h/00", i, d, r, i + 1);
      end
    end
    axi_read(5'h18, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL unmapped got=%h/%b want=0/00", d, r);
    end
  endtask

  task automatic test_stepping;
    logic [31:0] d;
    logic [1:0]  r;
    int p0;
    axi_write(5'h00, 32'h0, 4'hF, r);
    axi_write(5'h08, 32'h8020_0003, 4'hF, r);
    axi_write(5'h04, 32'h1, 4'hF, r);
    axi_write(5'h0C, 32'h3, 4'hF, r);
    p0 = pulses;
    axi_write(5'h00, 32'h1, 4'hF, r);
    repeat (20) tick();
    checks++;
    if (pulses - p0 !== 3) begin
      errors++; $display("FAIL step_pulses got=%0d want=3", pulses - p0);
    end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h6018_0001) begin
      errors++; $display("FAIL step_state got=%h want=60180001", d);
    end
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL step_count got=%h want=3", d); end
    repeat (20) tick();
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h6018_0001 || lfsr_out !== 32'h6018_0001) begin
      errors++; $display("FAIL step_hold got=%h/%h want=60180001", d, lfsr_out);
    end
  endtask

  task automatic test_zero_seed;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h00, 32'h0, 4'hF, r);
    axi_write(5'h04, 32'h0, 4'hF, r);
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL zseed_state got=%h want=1", d); end
    axi_read(5'h04, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL zseed_seed got=%h want=0", d); end
    axi_read(5'h14, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL zseed_count got=%h want=0", d); end
  endtask

  task automatic test_strobes;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h04, 32'hAABB_CCDD, 4'b0101, r);
    axi_read(5'h04, d, r);
    checks++;
    if (d !== 32'h00BB_00DD) begin
      errors++; $display("FAIL strb_seed got=%h want=00bb00dd", d);
    end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h00BB_00DD) begin
      errors++; $display("FAIL strb_state got=%h want=00bb00dd", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, d0;
    logic [1:0]  r;
    bus.awaddr = 5'h0C; bus.wdata = 32'h0; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    checks++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      errors++; $display("FAIL aw_lat got=%b want=11", {bus.awready, bus.wready});
    end
    tick();
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL b_lat got=%b want=1", bus.bvalid); end
    bus.awaddr = 5'h00; bus.wdata = 32'hF0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
        errors++;
        $display("FAIL b_hold_%0d got=%b/%b want=1/0", i, bus.bvalid, bus.awready);
      end
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0) begin
      errors++; $display("FAIL b_done got=%b/%b want=0/0", bus.bvalid, bus.awready);
    end
    tick();
    checks++;
    if (bus.awready !== 1'b1) begin
      errors++; $display("FAIL aw_requeue got=%b want=1", bus.awready);
    end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    axi_read(5'h00, d, r);
    checks++;
    if (d !== 32'hF0) begin errors++; $display("FAIL queued_ctrl got=%h want=f0", d); end
    axi_read(5'h0C, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL first_limit got=%h want=0", d); end

    axi_write(5'h00, 32'h1, 4'hF, r);
    bus.araddr = 5'h10; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    tick();
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL r_lat got=%b want=1", bus.rvalid); end
    d0 = bus.rdata;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rdata !== d0 || bus.rvalid !== 1'b1) begin
        errors++; $display("FAIL r_hold_%0d got=%h want=%h", i, bus.rdata, d0);
      end
    end
    checks++;
    if (lfsr_out === d0) begin
      errors++; $display("FAIL r_running got=%h want not %h", lfsr_out, d0);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    axi_write(5'h00, 32'h0, 4'hF, r);
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h08, 32'h1234_5678, 4'hF, r);
    axi_write(5'h00, 32'h1, 4'hF, r);
    bus.araddr = 5'h10; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    tick();
    bus.arvalid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0 || lfsr_out !== 32'h1) begin
      errors++;
      $display("FAIL async_rst got=%b/%h/%h want=0/0/1", bus.rvalid, bus.rdata, lfsr_out);
    end
    idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    axi_read(5'h08, d, r);
    checks++;
    if (d !== 32'h8020_0003) begin
      errors++; $display("FAIL rst_taps got=%h want=80200003", d);
    end
    axi_read(5'h10, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL rst_state_rd got=%h want=1", d); end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_stepping();
    test_zero_seed();
    test_strobes();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
